// File: rtl/cnt_pkg.sv
// ---------------------------------------------------------------------------
// cnt_pkg -- shared constants for the up/down counter family.
//
// Contents:
//   DIR_UP / DIR_DOWN      encoding of the counter's dir input
//   MODE_WRAP / MODE_SAT   encoding of the counter's sat_mode input
//   *_MIN / *_MAX          legal ranges for the counter parameters
//   max_count()            largest value representable in a given width
// ---------------------------------------------------------------------------
package cnt_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int WIDTH_MIN    = 2;
    localparam int WIDTH_MAX    = 32;
    localparam int MAX_VAL_MIN  = 1;
    localparam int PRESCALE_MIN = 2;
    localparam int PRESCALE_MAX = 256;

    // 64-bit arithmetic so that width 32 does not overflow.
    function automatic longint unsigned max_count(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// ---------------------------------------------------------------------------
// cnt_prescaler -- counts enabled cycles modulo PRESCALE and raises tick
// combinationally during the PRESCALE-th enabled cycle.
//
// Parameters:
//   PRESCALE  enabled cycles per tick (2..256)
// Ports:
//   clk   input   rising-edge clock
//   rst   input   synchronous, active-high reset
//   clr   input   synchronous clear of the partial count (beats en)
//   en    input   counts this cycle
//   tick  output  high in the enabled cycle that completes a period
// ---------------------------------------------------------------------------
module cnt_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int             CW   = $clog2(PRESCALE);
    localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = en & ~clr & (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// ---------------------------------------------------------------------------
// param_updown_counter -- loadable up/down counter with wrap or saturate
// behaviour at 0 / MAX_VAL, a one-cycle terminal-count pulse and a sticky
// boundary flag.
//
// Build option:
//   CNT_PRESCALE_EN  when defined, a cnt_prescaler divides enabled cycles so
//                    one step happens per PRESCALE enabled cycles; when
//                    undefined the counter steps on every enabled cycle.
//
// Parameters:
//   WIDTH     counter width (2..32)
//   MAX_VAL   top count value (1..2**WIDTH-1)
//   PRESCALE  enabled cycles per step (2..256), prescaled build only
// Ports:
//   clk       input   rising-edge clock
//   rst       input   synchronous, active-high reset
//   enable    input   step qualifier
//   dir       input   1 = up, 0 = down
//   sat_mode  input   1 = saturate at boundary, 0 = wrap
//   load      input   synchronous load strobe (beats stepping)
//   load_val  input   value to load, clamped to MAX_VAL
//   clr_ovf   input   clears ovf (a same-cycle boundary step wins)
//   count     output  registered count
//   tc        output  high the cycle after each boundary step
//   ovf       output  sticky boundary flag
// ---------------------------------------------------------------------------
module param_updown_counter
    import cnt_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MAX_VAL  = max_count(WIDTH),
    parameter int              PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             dir,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // ---------------------------------------------------------------
    // Parameter legality, rejected at elaboration.
    // ---------------------------------------------------------------
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("param_updown_counter: WIDTH %0d outside %0d..%0d",
               WIDTH, WIDTH_MIN, WIDTH_MAX);
    end
    if (MAX_VAL < MAX_VAL_MIN || MAX_VAL > max_count(WIDTH)) begin : g_bad_max
        $error("param_updown_counter: MAX_VAL %0d illegal for WIDTH %0d",
               MAX_VAL, WIDTH);
    end
    if (PRESCALE < PRESCALE_MIN || PRESCALE > PRESCALE_MAX) begin : g_bad_pre
        $error("param_updown_counter: PRESCALE %0d outside %0d..%0d",
               PRESCALE, PRESCALE_MIN, PRESCALE_MAX);
    end

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

    logic             step_tick;
    logic             step;
    logic             at_top;
    logic             at_bot;
    logic             boundary;
    logic [WIDTH-1:0] count_nxt;

    // ---------------------------------------------------------------
    // Step qualification.
    // ---------------------------------------------------------------
`ifdef CNT_PRESCALE_EN
    // Load restarts the prescale period; dir changes deliberately do not.
    cnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .en   (enable),
        .tick (step_tick)
    );
`else
    assign step_tick = 1'b1;
`endif

    assign step     = enable & ~load & step_tick;
    assign at_top   = (count == MAX_CNT);
    assign at_bot   = (count == '0);
    // A boundary step is any step taken from the edge in the current
    // direction, whether it wraps or saturates.
    assign boundary = step & ((dir == DIR_UP) ? at_top : at_bot);

    // ---------------------------------------------------------------
    // Next count.
    // ---------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        count_nxt = count;
        if (load) begin
            count_nxt = (load_val > MAX_CNT) ? MAX_CNT : load_val;
        end else if (step) begin
            if (dir == DIR_UP) begin
                if (at_top) count_nxt = (sat_mode == MODE_SAT) ? MAX_CNT : '0;
                else        count_nxt = count + WIDTH'(1);
            end else begin
                if (at_bot) count_nxt = (sat_mode == MODE_SAT) ? '0 : MAX_CNT;
                else        count_nxt = count - WIDTH'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // State registers.
    // ---------------------------------------------------------------
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            tc    <= boundary;
            // Setting beats clearing when both happen in one cycle.
            ovf   <= boundary | (ovf & ~clr_ovf);
        end
    end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1: top count value, legal range 1..2**WIDTH-1.
REQ-003 SHALL have parameter PRESCALE, default 4: enabled cycles per step, legal range 2..256; used only when CNT_PRESCALE_EN is defined.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-006 SHALL have port enable, input, 1: step qualifier.
REQ-007 SHALL have port dir, input, 1: 1 = count up, 0 = count down.
REQ-008 SHALL have port sat_mode, input, 1: 1 = saturate at boundary, 0 = wrap.
REQ-009 SHALL have port load, input, 1: synchronous load strobe.
REQ-010 SHALL have port load_val, input, WIDTH: value to load.
REQ-011 SHALL have port clr_ovf, input, 1: clears the sticky overflow flag.
REQ-012 SHALL have port count, output, WIDTH: registered count value.
REQ-013 SHALL have port tc, output, 1: registered one-cycle terminal-count pulse.
REQ-014 SHALL have port ovf, output, 1: registered sticky boundary flag.

Function
REQ-015 SHALL apply update priority: rst, then load, then step.
REQ-016 SHALL, on load, set count to min(load_val, MAX_VAL) on the next edge, drive tc low and leave ovf unchanged.
REQ-017 SHALL define a step event as enable=1 with load=0; with CNT_PRESCALE_EN defined, a step event additionally requires a prescaler tick.
REQ-018 SHALL, on an up step with count<MAX_VAL, set count to count+1; on a down step with count>0, set count to count-1.
REQ-019 SHALL, on an up step with count==MAX_VAL, set count to 0 when sat_mode=0 and hold MAX_VAL when sat_mode=1.
REQ-020 SHALL, on a down step with count==0, set count to MAX_VAL when sat_mode=0 and hold 0 when sat_mode=1.
REQ-021 SHALL drive tc high for exactly the cycle after each boundary step (REQ-019/020), including repeated boundary steps in saturate mode, and low otherwise.
REQ-022 SHALL set ovf on every boundary step, clear ovf on clr_ovf, and give set priority over clear when both occur in the same cycle.
REQ-023 SHALL hold count when enable=0 or no step event occurs, with tc low.
REQ-024 SHALL have a step latency of one cycle: the count change is visible at the edge that samples the step event.
REQ-025 SHALL allow dir and sat_mode to change on any cycle, taking effect on the same cycle's step.

Reset
REQ-026 SHALL, on rst=1 at a rising edge, set count=0, tc=0, ovf=0 and the prescaler count to 0, overriding load, enable and clr_ovf.
REQ-027 SHALL, when reset is asserted mid-count or mid-prescale, discard all partial progress; the first step after reset deasserts starts from 0.

Configuration
REQ-028 SHALL provide macro CNT_PRESCALE_EN; when defined, an internal prescaler counts enabled cycles modulo PRESCALE and ticks on the PRESCALE-th, so one step occurs per PRESCALE enabled cycles.
REQ-029 SHALL, with CNT_PRESCALE_EN defined, clear the prescaler on rst and on load; dir changes SHALL NOT clear it.
REQ-030 SHALL, without CNT_PRESCALE_EN, step on every enabled cycle, ignore PRESCALE and contain no prescaler logic.

Structure
REQ-031 SHALL take from shared package cnt_pkg: constants DIR_UP=1 and DIR_DOWN=0, constants MODE_WRAP=0 and MODE_SAT=1, and the parameter range-check constants.
REQ-032 SHALL implement the prescaler as sub-module cnt_prescaler (ports clk, rst, clr, en, tick), instantiated only under CNT_PRESCALE_EN.
REQ-033 SHALL reject illegal WIDTH, MAX_VAL or PRESCALE values with an elaboration-time error.

Verification
REQ-034 SHALL cover reset: rst=1 for 2 cycles with enable=1 and load=1 -> count=0, tc=0, ovf=0.
REQ-035 SHALL cover up wrap: WIDTH=4, MAX_VAL=9, dir=1, sat_mode=0, 10 steps -> count reaches 9 then 0; tc high one cycle after the 9->0 step; ovf=1.
REQ-036 SHALL cover down saturate: count=0, dir=0, sat_mode=1, 3 steps -> count stays 0, tc high 3 cycles, ovf=1; clr_ovf then clears ovf.
REQ-037 SHALL cover load: load_val=15 with MAX_VAL=9 -> count=9; load asserted together with enable -> load wins.
REQ-038 SHALL cover simultaneous events: clr_ovf asserted during a boundary step -> ovf stays 1.
REQ-039 SHALL cover prescale: CNT_PRESCALE_EN defined, PRESCALE=4, 12 enabled cycles -> count=3; rst after 2 enabled cycles -> next step occurs after 4 more enabled cycles.
